// File: rtl/break_pkg.sv
// Shared types and helpers for the break-away LED bank scheduler.
package break_pkg;

    // LEDs in the break-away bank.
    localparam int LED_WIDTH = 5;

    // Largest supported requester count; sizes the one-hot helper result.
    localparam int MAX_REQ = 8;

    // Scheduler states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_e;

    // One-hot encode index into a MAX_REQ-wide vector.
    // Bits at or above width are kept clear.
    function automatic logic [MAX_REQ-1:0] onehot(input int index, input int width);
        logic [MAX_REQ-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if ((i == index) && (i < width)) begin
                r[i] = 1'b1;
            end else begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first requesting index strictly after the pointer, with wrap.
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o
);

    // Scan offsets from farthest to nearest so the nearest requester after the pointer wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if ((k == ((int'(ptr_i) + off) % NUM_REQ)) && req_i[k]) begin
                    valid_o = 1'b1;
                    idx_o   = IDX_W'(k);
                end else begin
                    idx_o   = idx_o;
                end
            end
        end
    end

endmodule

// File: rtl/break_led_scheduler.sv
// Time-shares the break-away LED bank between NUM_REQ pattern sources.
// Round-robin ownership slots of SLOT_CYCLES cycles, with a one-cycle
// blanking gap whenever ownership changes or the owner lets go.
module break_led_scheduler
    import break_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int LED_WIDTH   = break_pkg::LED_WIDTH,
    parameter int SLOT_CYCLES = 12000000
) (
    input  logic                           i_clock,
    input  logic                           i_reset_n,
    input  logic [NUM_REQ-1:0]             i_req,
    input  logic [NUM_REQ*LED_WIDTH-1:0]   i_pattern,
    input  logic                           i_hold,
    output logic [NUM_REQ-1:0]             o_grant,
    output logic [LED_WIDTH-1:0]           o_leds,
    output logic                           o_busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SLOT_RELOAD = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [IDX_W-1:0] PTR_RESET   = IDX_W'(NUM_REQ - 1);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [LED_WIDTH-1:0]   leds_q, leds_d;
    logic                   busy_q, busy_d;

    logic                   pick_valid_s;
    logic [IDX_W-1:0]       pick_idx_s;
    logic [LED_WIDTH-1:0]   owner_pat_s;
    logic                   owner_req_s;
    logic                   others_req_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i   (i_req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid_s),
        .idx_o   (pick_idx_s)
    );

    // Registered grant is the owner one-hot while in OWN, so it qualifies the request lines.
    assign owner_req_s  = |(i_req & grant_q);
    assign others_req_s = |(i_req & ~grant_q);

    // Select the current owner's pattern slice.
    always_comb begin
        owner_pat_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (ptr_q == IDX_W'(k)) begin
                owner_pat_s = i_pattern[k*LED_WIDTH +: LED_WIDTH];
            end else begin
                owner_pat_s = owner_pat_s;
            end
        end
    end

    // State, pointer, slot counter and output registers.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            ptr_q   <= PTR_RESET;
            cnt_q   <= '0;
            grant_q <= '0;
            leds_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            leds_q  <= leds_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state: arbitration from IDLE/GAP, slot bookkeeping in OWN.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, GAP: begin
                if (pick_valid_s) begin
                    state_d = OWN;
                    ptr_d   = pick_idx_s;
                    cnt_d   = SLOT_RELOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN: begin
                if (!owner_req_s) begin
                    // Owner let go: the rest of its slot is forfeited.
                    state_d = GAP;
                end else if (cnt_q == '0) begin
                    if (i_hold || !others_req_s) begin
                        cnt_d = SLOT_RELOAD;
                    end else begin
                        state_d = GAP;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = PTR_RESET;
                cnt_d   = '0;
            end
        endcase
    end

    // Output next values: LEDs follow the owner only after a full OWN cycle, blank otherwise.
    always_comb begin
        grant_d = '0;
        leds_d  = '0;
        busy_d  = 1'b0;
        if (state_d == OWN) begin
            grant_d = NUM_REQ'(onehot(int'(ptr_d), NUM_REQ));
            busy_d  = 1'b1;
            if (state_q == OWN) begin
                leds_d = owner_pat_s;
            end else begin
                leds_d = '0;
            end
        end else begin
            grant_d = '0;
        end
    end

    assign o_grant = grant_q;
    assign o_leds  = leds_q;
    assign o_busy  = busy_q;

endmodule
